// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - fetch-side and decode-side handshake bundle for imm_gen_stage
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [5:0]      i_fmt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [31:0]     out_inst;
  logic            out_fmt_err;

  modport master (
    output in_valid, inst, i_fmt, out_ready,
    input  in_ready, out_valid, out_imm, out_inst, out_fmt_err
  );

  modport slave (
    input  in_valid, inst, i_fmt, out_ready,
    output in_ready, out_valid, out_imm, out_inst, out_fmt_err
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with 2-entry skid buffer
module imm_gen_stage #(
  parameter int XLEN          = 32,
  parameter bit DECODE_OPCODE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_stage_if.slave bus
);
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [5:0]      dec_fmt;
  logic [5:0]      fmt;
  logic            fmt_err;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [XLEN-1:0] new_imm;

  assign inst   = bus.inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    dec_fmt = 6'b000000;
    case (opcode)
      7'b0110011, 7'b0111011:                         dec_fmt = 6'b100000;
      7'b0010011, 7'b0011011, 7'b0000011,
      7'b1100111, 7'b1110011, 7'b0001111:             dec_fmt = 6'b010000;
      7'b0100011:                                     dec_fmt = 6'b001000;
      7'b1100011:                                     dec_fmt = 6'b000100;
      7'b0110111, 7'b0010111:                         dec_fmt = 6'b000010;
      7'b1101111:                                     dec_fmt = 6'b000001;
      default:                                        dec_fmt = 6'b000000;
    endcase
  end

  assign fmt     = DECODE_OPCODE ? dec_fmt : bus.i_fmt;
  assign fmt_err = (fmt == 6'b000000) || ((fmt & (fmt - 6'd1)) != 6'b000000);

  // Only the shift-immediate encodings carry a shamt; loads with funct3 001/101 stay sign-extended.
  assign is_shift = ((opcode == OP_IMM) || (opcode == OP_IMM_32)) &&
                    ((funct3 == 3'b001) || (funct3 == 3'b101));

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = ((XLEN == 64) && (opcode == OP_IMM)) ? {{(XLEN-6){1'b0}}, inst[25:20]}
                                                       : {{(XLEN-5){1'b0}}, inst[24:20]};

  always_comb begin
    new_imm = '0;
    if (!fmt_err) begin
      if (fmt[4])      new_imm = is_shift ? imm_sh : imm_i;
      else if (fmt[3]) new_imm = imm_s;
      else if (fmt[2]) new_imm = imm_b;
      else if (fmt[1]) new_imm = imm_u;
      else if (fmt[0]) new_imm = imm_j;
      else             new_imm = '0;
    end
  end

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_err_q, out_err_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic            skid_err_q, skid_err_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            drain;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_inst_d   = out_inst_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_inst_d  = skid_inst_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // Skid is only occupied while in_ready is low, so it never competes with an accept.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_inst_d   = skid_inst_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = new_imm;
        out_inst_d  = inst;
        out_err_d   = fmt_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm;
      skid_inst_d  = inst;
      skid_err_d   = fmt_err;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_inst_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_inst_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_inst_q   <= out_inst_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_inst_q  <= skid_inst_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_inst    = out_inst_q;
  assign bus.out_fmt_err = out_err_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench driving an XLEN=32/i_fmt and an XLEN=64/decoded stage in lockstep
module tb_imm_gen_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst;
  logic [5:0]  i_fmt;
  logic        out_ready;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) if_a ();
  imm_gen_stage_if #(.XLEN(64)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.inst      = inst;
  assign if_a.i_fmt     = i_fmt;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.inst      = inst;
  assign if_b.i_fmt     = i_fmt;
  assign if_b.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .DECODE_OPCODE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_a)
  );
  imm_gen_stage #(.XLEN(64), .DECODE_OPCODE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_b)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares the head entry every cycle out_valid is high (so stalls also prove hold), pops on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_match", {63'b0, if_a.in_ready}, {63'b0, if_b.in_ready});
      if (if_a.out_valid) begin
        if (qa.size() == 0) chk("a_unexpected_output", 64'd1, 64'd0);
        else begin
          chk("a_imm",  {32'b0, if_a.out_imm}, {32'b0, qa[0].imm[31:0]});
          chk("a_inst", {32'b0, if_a.out_inst}, {32'b0, qa[0].inst});
          chk("a_err",  {63'b0, if_a.out_fmt_err}, {63'b0, qa[0].err});
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (if_b.out_valid) begin
        if (qb.size() == 0) chk("b_unexpected_output", 64'd1, 64'd0);
        else begin
          chk("b_imm",  if_b.out_imm, qb[0].imm);
          chk("b_inst", {32'b0, if_b.out_inst}, {32'b0, qb[0].inst});
          chk("b_err",  {63'b0, if_b.out_fmt_err}, {63'b0, qb[0].err});
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [5:0] f,
                      input logic [63:0] ai, input logic ae,
                      input logic [63:0] bi, input logic be);
    logic acc;
    int   n;
    exp_t ea, eb;
    acc = 1'b0;
    n   = 0;
    ea  = '{imm: ai, inst: i, err: ae};
    eb  = '{imm: bi, inst: i, err: be};
    in_valid = 1'b1;
    inst     = i;
    i_fmt    = f;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = if_a.in_ready && !flush;
      @(posedge clk);
      if (acc) begin
        qa.push_back(ea);
        qb.push_back(eb);
      end
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    i_fmt     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {62'b0, if_a.out_valid, if_b.out_valid}, 64'd0);
    chk("rst_in_ready",  {62'b0, if_a.in_ready, if_b.in_ready}, 64'd3);
    chk("rst_imm",       if_b.out_imm | {32'b0, if_a.out_imm}, 64'd0);
    chk("rst_inst_err",  {if_a.out_inst | if_b.out_inst, 30'b0, if_a.out_fmt_err, if_b.out_fmt_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,-1 from an empty stage: one-cycle latency
    send(32'hFFF00093, 6'b010000, 64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("latency_out_valid", {62'b0, if_a.out_valid, if_b.out_valid}, 64'd3);
    // back-to-back stream at full rate
    send(32'h80109083, 6'b010000, 64'hFFFFF801, 1'b0, 64'hFFFFFFFFFFFFF801, 1'b0);
    send(32'h43F0D093, 6'b010000, 64'h0000001F, 1'b0, 64'h000000000000003F, 1'b0);
    send(32'hFE000EE3, 6'b000100, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'h800000B7, 6'b000010, 64'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    send(32'h00A00113, 6'b011000, 64'h0,        1'b1, 64'h000000000000000A, 1'b0);
    send(32'h00A00113, 6'b000000, 64'h0,        1'b1, 64'h000000000000000A, 1'b0);
    send(32'h1230007F, 6'b010000, 64'h00000123, 1'b0, 64'h0,                1'b1);
    send(32'h0080006F, 6'b000001, 64'h00000008, 1'b0, 64'h0000000000000008, 1'b0);
    send(32'hFE112E23, 6'b001000, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'h002081B3, 6'b100000, 64'h0,        1'b0, 64'h0,                1'b0);
    send(32'h03F0909B, 6'b010000, 64'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
    send(32'h00509093, 6'b010000, 64'h00000005, 1'b0, 64'h0000000000000005, 1'b0);
    idle(3);
    chk("stream_drained", 64'(qa.size() + qb.size()), 64'd0);

    // backpressure: two accepted, third held until out_ready rises
    out_ready = 1'b0;
    send(32'h43F0D093, 6'b010000, 64'h0000001F, 1'b0, 64'h000000000000003F, 1'b0);
    send(32'h800000B7, 6'b000010, 64'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    chk("bp_in_ready_low", {63'b0, if_a.in_ready}, 64'd0);
    fork
      send(32'hFE000EE3, 6'b000100, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_third_held", 64'(qa.size()), 64'd2);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", 64'(qa.size() + qb.size()), 64'd0);

    // flush with both entries full and a same-cycle input
    out_ready = 1'b0;
    send(32'hFFF00093, 6'b010000, 64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'h0080006F, 6'b000001, 64'h00000008, 1'b0, 64'h0000000000000008, 1'b0);
    in_valid = 1'b1;
    inst     = 32'h002081B3;
    i_fmt    = 6'b100000;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    qa.delete();
    qb.delete();
    chk("flush_out_valid", {62'b0, if_a.out_valid, if_b.out_valid}, 64'd0);
    chk("flush_in_ready",  {62'b0, if_a.in_ready, if_b.in_ready}, 64'd3);
    out_ready = 1'b1;
    idle(3);
    send(32'hFE112E23, 6'b001000, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    idle(3);
    chk("flush_recover", 64'(qa.size() + qb.size()), 64'd0);

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h43F0D093, 6'b010000, 64'h0000001F, 1'b0, 64'h000000000000003F, 1'b0);
    send(32'h800000B7, 6'b000010, 64'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {62'b0, if_a.out_valid, if_b.out_valid}, 64'd0);
    chk("arst_out_imm",   if_b.out_imm | {32'b0, if_a.out_imm}, 64'd0);
    chk("arst_out_inst",  {32'b0, if_a.out_inst | if_b.out_inst}, 64'd0);
    chk("arst_in_ready",  {62'b0, if_a.in_ready, if_b.in_ready}, 64'd3);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'h80109083, 6'b010000, 64'hFFFFF801, 1'b0, 64'hFFFFFFFFFFFFF801, 1'b0);
    idle(3);
    chk("final_drained", 64'(qa.size() + qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised successor to the combinational immediate generator. It sits between instruction fetch and the decode/execute boundary. It accepts one instruction per cycle over a valid/ready handshake and produces the XLEN-wide immediate plus a format-error flag. A 2-entry skid buffer provides full throughput under backpressure. It adds XLEN=64 shift handling, optional internal opcode-based format decode, and a flush input.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64 only.
DECODE_OPCODE, 0, format source. 0: the one-hot i_fmt port is used. 1: the format is decoded internally from inst[6:0] and i_fmt is ignored.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
inst  input  32  instruction word
i_fmt  input  6  one-hot format: [5]R [4]I [3]S [2]B [1]U [0]J
out_valid  output  1  out_imm/out_inst/out_fmt_err are valid
out_ready  input  1  downstream accepts the entry
out_imm  output  XLEN  generated immediate
out_inst  output  32  instruction associated with out_imm
out_fmt_err  output  1  format illegal (not one-hot, or undecodable opcode)

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_imm=0, out_inst=0, out_fmt_err=0, both buffer entries invalid, in_ready=1. Reset asserted mid-transfer drops all entries with no partial output.
- Handshake: a transfer occurs when valid&ready are both high at the clock edge. Entries leave in acceptance order. While out_valid=1 and out_ready=0, all out_* signals are held stable.
- Storage: an output register plus one skid register. in_ready is a registered signal: in_ready = !skid_valid.
- Latency: with the stage empty, an entry accepted at edge N appears with out_valid=1 after edge N (1 cycle).
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Simultaneous events:
  - Accept while the output drains: the new entry moves directly into the output register.
  - Accept with the output stalled: the entry goes to the skid register and in_ready drops next cycle.
  - Drain with the skid register occupied: the skid entry moves to the output register and in_ready rises.
- Flush: on the next edge, all entries are invalidated, out_valid=0 and in_ready=1. flush takes priority over a same-cycle in_valid (that input is dropped) and over out_ready.
- Immediate generation (combinational from inst/format, registered at accept), where s = inst[31] sign-extended to XLEN:
  - R: 0.
  - I: {s, inst[31:20]}.
  - S: {s, inst[31:25], inst[11:7]}.
  - B: {s, inst[7], inst[30:25], inst[11:8], 0}.
  - U: {s above bit 31, inst[31:12], 12'b0}. At XLEN=64, bits 63:32 replicate inst[31].
  - J: {s, inst[19:12], inst[20], inst[30:21], 0}.
- I-format shift exception: applies only when opcode is 0010011 (OP-IMM) or 0011011 (OP-IMM-32) AND funct3 is 001 or 101.
  - OP-IMM at XLEN=64: zero-extended inst[25:20].
  - OP-IMM at XLEN=32, or OP-IMM-32 at either width: zero-extended inst[24:20].
  - Loads and other I-formats with funct3 001/101 use the normal sign-extended I immediate.
- Format-error path: i_fmt zero or with more than one bit set (DECODE_OPCODE=0), or unknown opcode (DECODE_OPCODE=1), gives out_imm=0 and out_fmt_err=1. The entry still transfers; no latch-style hold of the previous value.
- Internal decode (DECODE_OPCODE=1):
  - 0110011, 0111011 → R
  - 0010011, 0011011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J

Test Plan:
- XLEN=32, out_ready=1: inst=0xFFF00093, i_fmt=010000 → out_imm=0xFFFFFFFF, out_fmt_err=0, out_valid one cycle after accept.
- lh (funct3=001) inst=0x80109083, I format → out_imm=0xFFFFF801 (not shamt 1). XLEN=64 srai inst=0x43F0D093 → out_imm=0x000000000000003F.
- B-type inst=0xFE000EE3, i_fmt=000100 (or DECODE_OPCODE=1) → out_imm=0xFFFFFFFC. At XLEN=64, U-type inst=0x800000B7 → out_imm=0xFFFFFFFF80000000.
- Backpressure: out_ready=0, three back-to-back in_valid → two accepted, in_ready=0, third held upstream. Raise out_ready → three outputs in order on consecutive cycles, no loss or duplication.
- i_fmt=011000 and i_fmt=000000 → out_imm=0, out_fmt_err=1. DECODE_OPCODE=1 with opcode 1111111 → same.
- Both buffers full, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, the input is dropped. Separately, pull rst_n low mid-stall → outputs zero immediately, without waiting for a clock edge.
